posit_mul_arbiter: RTL and testbench
====================================

Name: posit_mul_arbiter

Overview:
- Shares one pipelined posit32 multiplier (decoder -> exponent adder -> adjust -> round -> encoder, sequenced by the pipeline controller) between NUM_REQ requesters.
- Round-robin grants one issue per cycle and records the requester tag of every in-flight op in a tag FIFO.
- Routes each completed result, including the NAR/ZERO flags, back to the requester that issued it.
- Supports a drain sequence that quiesces the pipeline before reconfiguration or shutdown.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, posit operand/result width
- PIPE_LAT, 5, multiplier issue-to-done latency in cycles; tag FIFO depth = PIPE_LAT+1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester grant (one-hot or zero, combinational)
- req_a  in  NUM_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  operand B, same packing
- mul_valid  out  1  issue strobe to multiplier (registered)
- mul_a  out  DATA_W  issued operand A (registered)
- mul_b  out  DATA_W  issued operand B (registered)
- mul_done  in  1  multiplier result valid, one cycle per op
- mul_result  in  DATA_W  multiplier result
- mul_nar  in  1  result is NAR
- mul_zero  in  1  result is zero
- rsp_valid  out  NUM_REQ  one-hot response strobe (registered)
- rsp_result  out  DATA_W  response data, shared bus
- rsp_nar  out  1  response NAR flag
- rsp_zero  out  1  response ZERO flag
- drain_req  in  1  stop granting and empty the pipeline
- drain_done  out  1  level, pipeline empty while draining
- busy  out  1  tag FIFO non-empty
- err_orphan  out  1  sticky, mul_done arrived with no op in flight

Behaviour:
- Reset: all outputs 0, tag FIFO empty, state IDLE, rr_ptr = NUM_REQ-1 (requester 0 wins first). Assertion mid-operation discards in-flight tags; later mul_done pulses set err_orphan.
- Grant rule:
  - can_issue = (state != DRAIN) && (fifo_cnt < PIPE_LAT+1 || mul_done).
  - Winner is the first i with req_valid[i], searching rr_ptr+1 upward modulo NUM_REQ.
  - req_ready[winner] = can_issue; all other bits 0. req_ready never depends on req_ready.
- Handshake: req_valid[i] && req_ready[i] at a clock edge issues the op.
  - Next cycle: mul_valid=1 and mul_a/mul_b hold that requester's operands.
  - The tag i is pushed and rr_ptr <= i.
  - mul_valid is a one-cycle pulse; mul_a/mul_b hold their value when idle.
- Completion: mul_done pops the FIFO head tag t.
  - Next cycle: rsp_valid = one-hot(t), with rsp_result/rsp_nar/rsp_zero registered from mul_*.
  - Responses are strictly in issue order.
- Simultaneous push and pop in one cycle: fifo_cnt unchanged; legal when full.
- mul_done with FIFO empty and no same-cycle push: no response, err_orphan <= 1 until reset.
- FIFO pointers wrap modulo PIPE_LAT+1; fifo_cnt width is clog2(PIPE_LAT+2).
- FSM:
  - IDLE: fifo empty. Goes to ACTIVE on a handshake, to DRAIN on drain_req.
  - ACTIVE: goes to IDLE when the count reaches 0 with no push; goes to DRAIN on drain_req.
  - DRAIN: no grants. drain_done=1 when fifo_cnt==0 and mul_valid==0. Returns to IDLE when drain_req deasserts.
- busy = (fifo_cnt != 0) || mul_valid.

Optional Feature:
- HIPRI_REQ0_EN defined: requester 0 wins whenever req_valid[0] is set and can_issue; the other requesters round-robin among themselves. rr_ptr is not updated on requester-0 grants.
- Undefined: pure round-robin over all NUM_REQ requesters.

Test Plan:
- Single op: requester 2 issues a=0x40000000 (1.0), b=0x48000000 (2.0); model returns 0x48000000 after 5 cycles -> rsp_valid=4'b0100, rsp_result=0x48000000, nar=0, zero=0, busy falls after the response.
- Fairness: all four req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3. With HIPRI_REQ0_EN -> 0 every cycle.
- Backpressure: mul_done held low with 6 ops issued -> req_ready=0 on cycle 7. A mul_done pulse -> a grant in that same cycle, fifo_cnt stays 6.
- Special values: model returns result 0x80000000 with mul_nar=1 for requester 1's op -> rsp_valid=4'b0010, rsp_nar=1, rsp_result=0x80000000. A zero result -> rsp_zero=1.
- Drain: drain_req raised with 3 ops in flight -> no grants; drain_done=1 the cycle after the third rsp_valid; drain_req low -> IDLE and grants resume.
- Orphan/reset: rst pulsed with 2 ops in flight, then 2 mul_done pulses -> no rsp_valid, err_orphan=1 and stays 1.

Source files
------------

// File: rtl/posit_mul_arbiter.sv
// Shares one pipelined posit multiplier among NUM_REQ requesters and routes results back by tag.
// Optional macro HIPRI_REQ0_EN: requester 0 gets strict priority; the others round-robin.
module posit_mul_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int PIPE_LAT = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      mul_valid,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic                      mul_done,
  input  logic [DATA_W-1:0]         mul_result,
  input  logic                      mul_nar,
  input  logic                      mul_zero,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_nar,
  output logic                      rsp_zero,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic                      busy,
  output logic                      err_orphan
);
  localparam int DEPTH = PIPE_LAT + 1;
  localparam int CNT_W = $clog2(PIPE_LAT + 2);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TAG_W = $clog2(NUM_REQ);
`ifdef HIPRI_REQ0_EN
  localparam bit HIPRI = 1'b1;
`else
  localparam bit HIPRI = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt, cnt_nxt;
  logic [TAG_W-1:0]  rr_ptr, winner, head_tag, idx;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic              found, can_issue, push, pop, fifo_empty, orphan_hit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Winner search starts just after the last granted requester
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = rr_ptr;
    if (HIPRI && req_valid[0]) found = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == TAG_W'(NUM_REQ - 1)) ? '0 : idx + TAG_W'(1);
      if (!found && req_valid[idx] && !(HIPRI && idx == '0)) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == TAG_W'(i)) begin
        sel_a = req_a[i*DATA_W +: DATA_W];
        sel_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign fifo_empty = (fifo_cnt == '0);
  assign can_issue  = (state != DRAIN) && ((fifo_cnt < CNT_W'(DEPTH)) || mul_done);
  assign push       = found && can_issue;
  // An empty FIFO with a same-cycle push hands the new tag straight to the pop
  assign pop        = mul_done && (!fifo_empty || push);
  assign orphan_hit = mul_done && fifo_empty && !push;
  assign head_tag   = fifo_empty ? winner : tag_mem[rd_ptr];

  always_comb begin
    req_ready = '0;
    if (push) req_ready[winner] = 1'b1;
  end

  always_comb begin
    cnt_nxt = fifo_cnt;
    if (push && !pop)      cnt_nxt = fifo_cnt + CNT_W'(1);
    else if (pop && !push) cnt_nxt = fifo_cnt - CNT_W'(1);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (drain_req) state_nxt = DRAIN;
               else if (push) state_nxt = ACTIVE;
      ACTIVE:  if (drain_req) state_nxt = DRAIN;
               else if (cnt_nxt == '0 && !push) state_nxt = IDLE;
      DRAIN:   if (!drain_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue / completion register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fifo_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rr_ptr     <= TAG_W'(NUM_REQ - 1);
      mul_valid  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_nar    <= 1'b0;
      rsp_zero   <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      state     <= state_nxt;
      fifo_cnt  <= cnt_nxt;
      mul_valid <= push;
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
        mul_a  <= sel_a;
        mul_b  <= sel_b;
        if (!(HIPRI && winner == '0)) rr_ptr <= winner;
      end
      if (pop) begin
        rd_ptr     <= ptr_inc(rd_ptr);
        rsp_result <= mul_result;
        rsp_nar    <= mul_nar;
        rsp_zero   <= mul_zero;
      end
      rsp_valid <= pop ? (NUM_REQ'(1) << head_tag) : '0;
      if (orphan_hit) err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= winner;
  end

  assign drain_done = (state == DRAIN) && fifo_empty && !mul_valid;
  assign busy       = !fifo_empty || mul_valid;

endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Self-checking bench for posit_mul_arbiter: directed scenarios plus a randomized phase
// checked against a queue-based model of the arbiter and a stub multiplier.
module tb_posit_mul_arbiter;
  localparam int N = 4, W = 32, L = 5, DEPTH = L + 1, TW = $clog2(N);
`ifdef HIPRI_REQ0_EN
  localparam bit HIPRI = 1'b1;
`else
  localparam bit HIPRI = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [N*W-1:0] req_a, req_b;
  logic mul_valid, mul_done, mul_nar, mul_zero, rsp_nar, rsp_zero;
  logic [W-1:0] mul_a, mul_b, mul_result, rsp_result;
  logic drain_req, drain_done, busy, err_orphan;

  always #5 clk = ~clk;

  posit_mul_arbiter #(.NUM_REQ(N), .DATA_W(W), .PIPE_LAT(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result), .mul_nar(mul_nar), .mul_zero(mul_zero),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_nar(rsp_nar), .rsp_zero(rsp_zero),
    .drain_req(drain_req), .drain_done(drain_done), .busy(busy), .err_orphan(err_orphan)
  );

  int total = 0, bad = 0, cyc = 0;
  int tagq[$];
  int mq_cyc[$];
  logic [W-1:0] mq_res[$];
  logic mq_nar[$], mq_zero[$];
  int m_last;
  bit m_drain;
  logic exp_mv, exp_nar, exp_zero, exp_orphan;
  logic [W-1:0] exp_ma, exp_mb, exp_res;
  logic [N-1:0] exp_rsp, obs_ready;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stub multiplier: exact for NAR, zero and 1.0 operands, arbitrary mixing otherwise
  function automatic logic [W+1:0] pmul(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 32'h8000_0000 || b == 32'h8000_0000) return {2'b10, 32'h8000_0000};
    if (a == '0 || b == '0) return {2'b01, 32'h0};
    if (a == 32'h4000_0000) return {2'b00, b};
    if (b == 32'h4000_0000) return {2'b00, a};
    return {2'b00, a ^ {b[15:0], b[31:16]}};
  endfunction

  // done_mode: 0 = multiplier stalls, 1 = completes oldest op once old enough, 2 = forced pulse
  task automatic tick(input logic [N-1:0] rv, input bit drain, input int done_mode);
    bit done, found, can, push;
    int win, idx;
    logic [W+1:0] m;
    logic [W-1:0] dres;
    logic dnar, dzero;
    req_valid = rv;
    drain_req = drain;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
    done = (done_mode == 2) || (done_mode == 1 && mq_cyc.size() > 0 && cyc - mq_cyc[0] >= L);
    dres  = (done && mq_res.size() > 0) ? mq_res[0] : '0;
    dnar  = (done && mq_nar.size() > 0) ? mq_nar[0] : 1'b0;
    dzero = (done && mq_zero.size() > 0) ? mq_zero[0] : 1'b0;
    mul_done = done; mul_result = dres; mul_nar = dnar; mul_zero = dzero;
    found = 0; win = 0;
    if (HIPRI && rv[0]) found = 1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (!found && rv[TW'(idx)] && !(HIPRI && idx == 0)) begin found = 1; win = idx; end
    end
    can  = !m_drain && (tagq.size() < DEPTH || done);
    push = found && can;
    #1;
    obs_ready = req_ready;
    chk("req_ready", 64'(req_ready), push ? 64'(1) << win : 64'(0));
    exp_rsp = '0;
    if (done) begin
      if (tagq.size() > 0) exp_rsp = N'(1) << tagq.pop_front();
      else if (push) exp_rsp = N'(1) << win;
      else exp_orphan = 1'b1;
      if (exp_rsp != '0) begin exp_res = dres; exp_nar = dnar; exp_zero = dzero; end
      if (mq_cyc.size() > 0) begin
        void'(mq_cyc.pop_front()); void'(mq_res.pop_front());
        void'(mq_nar.pop_front()); void'(mq_zero.pop_front());
      end
    end
    if (push) begin
      tagq.push_back(win);
      m = pmul(op_a[TW'(win)], op_b[TW'(win)]);
      mq_cyc.push_back(cyc); mq_res.push_back(m[W-1:0]);
      mq_nar.push_back(m[W+1]); mq_zero.push_back(m[W]);
      exp_ma = op_a[TW'(win)];
      exp_mb = op_b[TW'(win)];
      if (!(HIPRI && win == 0)) m_last = win;
    end
    exp_mv  = push;
    m_drain = drain;
    @(posedge clk); #1;
    chk("mul_valid", 64'(mul_valid), 64'(exp_mv));
    chk("mul_a", 64'(mul_a), 64'(exp_ma));
    chk("mul_b", 64'(mul_b), 64'(exp_mb));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    chk("busy", 64'(busy), 64'(tagq.size() != 0 || exp_mv));
    chk("drain_done", 64'(drain_done), 64'(m_drain && tagq.size() == 0 && !exp_mv));
    chk("err_orphan", 64'(err_orphan), 64'(exp_orphan));
    if (exp_rsp != '0) begin
      chk("rsp_result", 64'(rsp_result), 64'(exp_res));
      chk("rsp_nar", 64'(rsp_nar), 64'(exp_nar));
      chk("rsp_zero", 64'(rsp_zero), 64'(exp_zero));
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit clear_mul);
    rst = 1'b1; req_valid = '0; drain_req = 1'b0; mul_done = 1'b0;
    #1;
    chk("rst_mul_valid", 64'(mul_valid), 64'(0));
    chk("rst_mul_a", 64'(mul_a), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_result", 64'(rsp_result), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_drain_done", 64'(drain_done), 64'(0));
    chk("rst_err_orphan", 64'(err_orphan), 64'(0));
    tagq.delete();
    if (clear_mul) begin mq_cyc.delete(); mq_res.delete(); mq_nar.delete(); mq_zero.delete(); end
    m_last = N - 1; m_drain = 0; exp_mv = 0; exp_ma = '0; exp_mb = '0;
    exp_orphan = 0; exp_rsp = '0;
    @(posedge clk); cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic flush();
    for (int i = 0; i < 40; i++) begin
      if (tagq.size() == 0 && mq_cyc.size() == 0 && !exp_mv) break;
      tick('0, 0, 1);
    end
    chk("flush_idle", 64'(busy), 64'(0));
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 12; i++) begin
      tick('0, 0, 1);
      if (exp_rsp != '0) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrsp;
    rst = 1'b0; req_valid = '0; drain_req = 0; mul_done = 0; mul_result = '0;
    mul_nar = 0; mul_zero = 0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
    #2;
    do_reset(1);

    // Fairness from reset: requester 0 first, then rotate
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) begin op_a[i] = $urandom; op_b[i] = $urandom; end
      tick('1, 0, 1);
      chk("fair_order", 64'(obs_ready), 64'(1) << (HIPRI ? 0 : k % N));
    end
    flush();

    // Single op: 1.0 * 2.0 from requester 2
    op_a[2] = 32'h4000_0000; op_b[2] = 32'h4800_0000;
    tick(4'b0100, 0, 1);
    wait_rsp();
    chk("single_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    chk("single_rsp_result", 64'(rsp_result), 64'h4800_0000);
    chk("single_rsp_nar", 64'(rsp_nar), 64'(0));
    chk("single_rsp_zero", 64'(rsp_zero), 64'(0));
    tick('0, 0, 1);
    chk("single_busy_after", 64'(busy), 64'(0));

    // Backpressure: six ops fill the tag FIFO while the multiplier stalls
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin op_a[i] = $urandom; op_b[i] = $urandom; end
      tick('1, 0, 0);
    end
    tick('1, 0, 0);
    chk("bp_full_no_grant", 64'(obs_ready), 64'(0));
    tick('1, 0, 1);
    chk("bp_grant_on_done", 64'($countones(obs_ready)), 64'(1));
    tick('1, 0, 0);
    chk("bp_still_full", 64'(obs_ready), 64'(0));
    flush();

    // Special values: NAR from requester 1, zero from requester 3
    op_a[1] = 32'h8000_0000; op_b[1] = 32'h1234_5678;
    tick(4'b0010, 0, 1);
    wait_rsp();
    chk("nar_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    chk("nar_flag", 64'(rsp_nar), 64'(1));
    chk("nar_result", 64'(rsp_result), 64'h8000_0000);
    op_a[3] = 32'h0; op_b[3] = 32'h5555_0001;
    tick(4'b1000, 0, 1);
    wait_rsp();
    chk("zero_rsp_valid", 64'(rsp_valid), 64'(4'b1000));
    chk("zero_flag", 64'(rsp_zero), 64'(1));
    chk("zero_result", 64'(rsp_result), 64'(0));
    flush();

    // Drain with three ops in flight
    for (int k = 0; k < 3; k++) tick(4'b0111, 0, 1);
    tick('0, 1, 1);
    nrsp = 0;
    for (int i = 0; i < 12 && nrsp < 3; i++) begin
      tick('1, 1, 1);
      chk("drain_no_grant", 64'(obs_ready), 64'(0));
      if (rsp_valid != '0) nrsp++;
    end
    chk("drain_rsp_count", 64'(nrsp), 64'(3));
    tick('1, 1, 1);
    chk("drain_done_high", 64'(drain_done), 64'(1));
    tick('1, 0, 1);
    chk("drain_exit_cycle", 64'(obs_ready), 64'(0));
    tick('1, 0, 1);
    chk("drain_grants_resume", 64'($countones(obs_ready)), 64'(1));
    flush();

    // Randomized traffic with stalls and occasional drains
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = ($urandom_range(0, 7) == 0) ? 32'h4000_0000 : $urandom;
        op_b[i] = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      end
      tick(N'($urandom), $urandom_range(0, 11) == 0, ($urandom_range(0, 3) != 0) ? 1 : 0);
    end
    flush();

    // Reset with two ops in flight; their completions become orphans
    tick(4'b0011, 0, 1);
    tick(4'b0011, 0, 1);
    do_reset(0);
    nrsp = 0;
    for (int i = 0; i < 10; i++) begin
      tick('0, 0, 1);
      if (rsp_valid != '0) nrsp++;
    end
    chk("orphan_no_rsp", 64'(nrsp), 64'(0));
    chk("orphan_set", 64'(err_orphan), 64'(1));
    tick('0, 0, 0);
    tick('0, 0, 0);
    chk("orphan_sticky", 64'(err_orphan), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
